fetch_queue: RTL and testbench

- Instruction prefetch buffer between the instruction fetch unit and the register/decode stage of the 5-stage pipeline.
- Decouples fetch from decode stalls by holding up to DEPTH fetched instructions with their PCs.
- Presents the head entry to decode: instruction, its PC, and the precomputed link/delay-slot address PC+8.
- Discards all buffered entries on a branch/jump redirect (flush).

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 59 +++++
 tb/tb_fetch_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch unit (master) and the prefetch queue (slave).
// Decode-side signals ride along so the queue has a single bus port.
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc8;
  logic [31:0]   out_instr;
  logic          flush;
  logic [AW:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_pc8, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_pc8, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode: holds up to DEPTH {pc, instr}
// entries, presents the head with its PC+8 link address, and empties on a redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic            clock,
  input  logic            reset,
  fetch_queue_if.slave    bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;
  logic          not_empty;

  assign not_empty = (cnt != '0);
  assign push      = bus.in_valid && bus.in_ready;
  assign pop       = not_empty && bus.out_ready;

  // Everything decode sees comes from registered state, so there is no in_* to out_* bypass.
  assign bus.in_ready  = (cnt < FULL);
  assign bus.out_valid = not_empty;
  assign bus.count     = cnt;
  assign bus.out_instr = not_empty ? instr_mem[rptr] : NOP_WORD;
  assign bus.out_pc    = not_empty ? pc_mem[rptr] : 32'h0;
  assign bus.out_pc8   = bus.out_pc + 32'd8;

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)
        cnt <= cnt + (AW+1)'(1);
      else if (pop && !push)
        cnt <= cnt - (AW+1)'(1);
    end
  end

  // Storage is deliberately not reset; a push during flush is dropped with the rest.
  always_ff @(posedge clock) begin
    if (push && !bus.flush && !reset) begin
      pc_mem[wptr]    <= bus.in_pc;
      instr_mem[wptr] <= bus.in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic   clock = 1'b0;
  logic   reset;
  entry_t model_q[$];
  int     checkCount = 0;
  int     passCount  = 0;
  bit     justReset  = 1'b0;

  always #5 clock = ~clock;

  fetch_queue_if #(.AW(AW)) bus ();

  fetch_queue #(
    .DEPTH(DEPTH),
    .AW(AW),
    .NOP_WORD(32'h00000000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
  endtask

  task automatic checkAll();
    int n;
    n = model_q.size();
    checkOutput("count", 32'(bus.count), 32'(n));
    checkOutput("in_ready", 32'(bus.in_ready), (n < DEPTH) ? 32'd1 : 32'd0);
    checkOutput("out_valid", 32'(bus.out_valid), (n != 0) ? 32'd1 : 32'd0);
    checkOutput("out_instr", bus.out_instr, (n != 0) ? model_q[0].instr : 32'h0);
    if (n != 0) begin
      checkOutput("out_pc", bus.out_pc, model_q[0].pc);
      checkOutput("out_pc8", bus.out_pc8, model_q[0].pc + 32'd8);
    end
    if (justReset) begin
      checkOutput("rst_out_pc", bus.out_pc, 32'h0);
      checkOutput("rst_out_pc8", bus.out_pc8, 32'h8);
    end
  endtask

  // Drive one cycle of inputs from the falling edge, advance the model at the rising edge, check at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
    bit pushOk;
    bit popOk;
    reset        = rst;
    bus.flush    = fl;
    bus.in_valid = iv;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    bus.out_ready = ordy;
    @(posedge clock);
    pushOk = iv && (model_q.size() < DEPTH);
    popOk  = ordy && (model_q.size() != 0);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (popOk) void'(model_q.pop_front());
      if (pushOk) model_q.push_back('{pc: pc, instr: instr});
    end
    justReset = rst;
    @(negedge clock);
    checkAll();
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Fill to full while decode stalls; the fifth push must be dropped.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 32'(i * 4), 32'hA0 + 32'(i), 0);
    applyStimulus(0, 0, 1, 32'h10, 32'hA4, 0);
    checkOutput("full_head_pc8", bus.out_pc8, 32'h8);
    checkOutput("full_head_instr", bus.out_instr, 32'hA0);

    // Drain with no pushes.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("drained_nop", bus.out_instr, 32'h0);

    // Steady state at two entries with simultaneous push/pop across wrap-around.
    applyStimulus(0, 0, 1, 32'h100, 32'hB0, 0);
    applyStimulus(0, 0, 1, 32'h104, 32'hB1, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 1, 32'h108 + 32'(i * 4), 32'hB2 + 32'(i), 1);
    checkOutput("steady_count", 32'(bus.count), 32'd2);

    // Flush at three entries with a concurrent push that must vanish.
    applyStimulus(0, 0, 1, 32'h200, 32'hC0, 0);
    applyStimulus(0, 1, 1, 32'h40, 32'hC1, 0);
    applyStimulus(0, 0, 1, 32'h80, 32'hC2, 0);
    checkOutput("post_flush_pc", bus.out_pc, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // PC+8 wraps modulo 2^32.
    applyStimulus(0, 0, 1, 32'hFFFFFFFC, 32'hD0, 0);
    checkOutput("pc8_wrap", bus.out_pc8, 32'h4);
    applyStimulus(0, 0, 1, 32'h300, 32'hD1, 0);

    // Reset wins over flush mid-operation.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic rst_r, fl_r;
      rst_r = ($urandom_range(63) == 0);
      fl_r  = ($urandom_range(15) == 0);
      applyStimulus(rst_r, fl_r, 1'($urandom_range(1)), $urandom & 32'hFFFFFFFC,
                    $urandom, 1'($urandom_range(1)));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end
endmodule
